n64_console: RTL and testbench

- Host-side N64 joybus poller: periodically sends the 0x01 status/poll command on the single-wire bus to an attached N64 controller.
- Decodes the 32-bit reply into button and stick state.
- Counterpart of n64_controller (device side), for bridging a real N64 pad into the design.
- Output bit order matches n64_controller's button_state, so the two can be chained directly.

---
 rtl/n64_console.sv | 273 +++++++++++++++++++++++++++
 tb/tb_n64_console.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_console.sv
// n64_console -- host-side N64 joybus poller.
//
// Periodically sends the 0x01 status command on the single-wire joybus,
// then receives the controller's 32-bit reply and decodes it into button
// and analog-stick state. button_state uses the same bit order as
// n64_controller, so a real pad bridged through this block can feed that
// device model directly.
//
// Ports:
//   sample_clk     in   system clock
//   rst_n          in   synchronous reset, active-low
//   enable         in   1 = polling allowed (only checked between polls)
//   data_rx        in   bus level, asynchronous (1 = line high)
//   data_tx        out  1 = pull the bus low (open-drain drive)
//   cur_operation  out  1 = transmitting (bus owned), 0 = listening
//   button_state   out  last good buttons, bit k = reply wire bit k
//   stick_x        out  last good X axis, two's complement
//   stick_y        out  last good Y axis, two's complement
//   poll_done      out  1-cycle pulse when a new reply is committed
//   poll_error     out  1-cycle pulse when a poll fails

module n64_console #(
    parameter int US_CYCLES  = 16,
    parameter int POLL_US    = 1000,
    parameter int TIMEOUT_US = 100
) (
    input  logic        sample_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        data_rx,
    output logic        data_tx,
    output logic        cur_operation,
    output logic [15:0] button_state,
    output logic [7:0]  stick_x,
    output logic [7:0]  stick_y,
    output logic        poll_done,
    output logic        poll_error
);

    localparam int CELL_CYC = 4 * US_CYCLES;
    localparam int POLL_CYC = POLL_US * US_CYCLES;
    localparam int TO_CYC   = TIMEOUT_US * US_CYCLES;
    localparam int MAX_A    = (POLL_CYC > TO_CYC) ? POLL_CYC : TO_CYC;
    localparam int MAX_CYC  = (MAX_A > CELL_CYC) ? MAX_A : CELL_CYC;
    localparam int CW       = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] ONE_U       = CW'(US_CYCLES);
    localparam logic [CW-1:0] THREE_U     = CW'(3 * US_CYCLES);
    localparam logic [CW-1:0] CELL_LAST   = CW'(CELL_CYC - 1);
    localparam logic [CW-1:0] STOP_LAST   = CW'(3 * US_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(2 * US_CYCLES - 1);
    localparam logic [CW-1:0] POLL_LAST   = CW'(POLL_CYC - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(TO_CYC - 1);

    localparam logic [7:0] POLL_CMD = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_BIT,
        S_TX_STOP,
        S_RX_WAIT,
        S_RX_BIT,
        S_RX_STOP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [4:0]    bit_idx;
    logic [31:0]   rx_buf;
    logic          stop_fell;

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic          rx_fall;
    logic          rx_rise;

    logic [2:0]    cmd_idx;
    logic [CW-1:0] tx_hi_len;

    // Two-flop synchronizer plus one history flop for edge detection.
    // Reset to the idle (high) bus level so release never looks like an edge.
    always_ff @(posedge sample_clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= data_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // While we own the bus the line only echoes our own drive, so edges
    // seen then are not from the controller and are masked.
    assign rx_fall = rx_prev & ~rx_sync & ~cur_operation;
    assign rx_rise = ~rx_prev & rx_sync & ~cur_operation;

    assign cnt_inc = cnt + CW'(1);

    // Command bits go out MSB first: cell 0 carries bit 7. A 1 is a short
    // pulse (1U released-high after the cell start), a 0 is a long one.
    always_comb begin
        cmd_idx   = 3'd7 - bit_idx[2:0];
        tx_hi_len = POLL_CMD[cmd_idx] ? ONE_U : THREE_U;
    end

    // Main poll sequencer. data_tx/cur_operation are registered and are
    // assigned the value that belongs to the next cycle, so the waveform
    // lines up exactly with the cell counter. poll_done/poll_error are set
    // on the transition into DONE/ERROR so they coincide with those states.
    always_ff @(posedge sample_clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            rx_buf        <= '0;
            stop_fell     <= 1'b0;
            data_tx       <= 1'b0;
            cur_operation <= 1'b0;
            button_state  <= '0;
            stick_x       <= '0;
            stick_y       <= '0;
            poll_done     <= 1'b0;
            poll_error    <= 1'b0;
        end else begin
            poll_done  <= 1'b0;
            poll_error <= 1'b0;

            case (state)
                // Idle gap; the counter parks at terminal count until
                // polling is enabled.
                S_IDLE: begin
                    if (cnt == POLL_LAST) begin
                        if (enable) begin
                            state         <= S_TX_BIT;
                            cnt           <= '0;
                            bit_idx       <= '0;
                            data_tx       <= 1'b1;
                            cur_operation <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // Every cell starts with the line pulled low.
                S_TX_BIT: begin
                    if (cnt == CELL_LAST) begin
                        cnt     <= '0;
                        data_tx <= 1'b1;
                        if (bit_idx == 5'd7) begin
                            state   <= S_TX_STOP;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                        end
                    end else begin
                        cnt     <= cnt_inc;
                        data_tx <= (cnt_inc < tx_hi_len);
                    end
                end

                // Host stop bit: 1U low, 2U released, then hand the bus over.
                S_TX_STOP: begin
                    if (cnt == STOP_LAST) begin
                        cnt           <= '0;
                        data_tx       <= 1'b0;
                        cur_operation <= 1'b0;
                        state         <= S_RX_WAIT;
                    end else begin
                        cnt     <= cnt_inc;
                        data_tx <= (cnt_inc < ONE_U);
                    end
                end

                S_RX_WAIT: begin
                    if (rx_fall) begin
                        cnt   <= '0;
                        state <= S_RX_BIT;
                    end else if (cnt == TO_LAST) begin
                        cnt        <= '0;
                        state      <= S_ERROR;
                        poll_error <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // Sample mid-cell; extra falling edges before then are
                // simply not looked at, which gives glitch tolerance.
                S_RX_BIT: begin
                    if (cnt == SAMPLE_LAST) begin
                        rx_buf[bit_idx] <= rx_sync;
                        cnt             <= '0;
                        if (bit_idx == 5'd31) begin
                            state     <= S_RX_STOP;
                            stop_fell <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            state   <= S_RX_WAIT;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                // Controller stop bit: a fall then a rise, each with its
                // own timeout window.
                S_RX_STOP: begin
                    if (!stop_fell) begin
                        if (rx_fall) begin
                            stop_fell <= 1'b1;
                            cnt       <= '0;
                        end else if (cnt == TO_LAST) begin
                            cnt        <= '0;
                            state      <= S_ERROR;
                            poll_error <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        if (rx_rise) begin
                            cnt          <= '0;
                            state        <= S_DONE;
                            poll_done    <= 1'b1;
                            button_state <= rx_buf[15:0];
                            // Stick bytes arrive MSB first on the wire.
                            for (int i = 0; i < 8; i++) begin
                                stick_x[7 - i] <= rx_buf[16 + i];
                                stick_y[7 - i] <= rx_buf[24 + i];
                            end
                        end else if (cnt == TO_LAST) begin
                            cnt        <= '0;
                            state      <= S_ERROR;
                            poll_error <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    bit_idx   <= '0;
                    stop_fell <= 1'b0;
                end

                // A failed reply leaves the published state untouched.
                S_ERROR: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    bit_idx   <= '0;
                    stop_fell <= 1'b0;
                    rx_buf    <= '0;
                end

                default: begin
                    state         <= S_IDLE;
                    cnt           <= '0;
                    data_tx       <= 1'b0;
                    cur_operation <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n64_console.sv
// tb_n64_console -- self-checking bench for n64_console.
//
// Models an N64 controller on an open-drain bus (wired-AND of host drive
// and device drive), applies a table of reply scenarios plus random replies
// checked against a decode model, and runs hand sequences for waveform
// timing, timeouts, reset during transmit and enable drop mid-reply.

module tb_n64_console;

    localparam int US       = 4;
    localparam int PUS      = 50;
    localparam int TUS      = 10;
    localparam int U        = US;
    localparam int POLL_CYC = PUS * US;
    localparam int TO_CYC   = TUS * US;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        dev_low;
    logic        data_rx;
    logic        data_tx;
    logic        cur_operation;
    logic [15:0] button_state;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
    logic        poll_done;
    logic        poll_error;

    int total = 0;
    int bad   = 0;

    // Open-drain bus: low if either side pulls.
    assign data_rx = ~(data_tx | dev_low);

    always #5 clk = ~clk;

    n64_console #(
        .US_CYCLES (US),
        .POLL_US   (PUS),
        .TIMEOUT_US(TUS)
    ) dut (
        .sample_clk   (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .data_rx      (data_rx),
        .data_tx      (data_tx),
        .cur_operation(cur_operation),
        .button_state (button_state),
        .stick_x      (stick_x),
        .stick_y      (stick_y),
        .poll_done    (poll_done),
        .poll_error   (poll_error)
    );

    // Event monitor, sampled 2 time units after each rising edge.
    int   done_cnt  = 0;
    int   err_cnt   = 0;
    int   start_cnt = 0;
    int   viol_cnt  = 0;
    int   both_cnt  = 0;
    logic cop_prev  = 1'b0;

    always @(posedge clk) begin
        #2;
        if (poll_done === 1'b1) done_cnt++;
        if (poll_error === 1'b1) err_cnt++;
        if (poll_done === 1'b1 && poll_error === 1'b1) both_cnt++;
        if (cur_operation === 1'b1 && cop_prev !== 1'b1) start_cnt++;
        if (data_tx === 1'b1 && cur_operation !== 1'b1) viol_cnt++;
        cop_prev = cur_operation;
    end

    typedef struct {
        logic [31:0] reply;
        int          nbits;
        bit          stop;
        int          exp_done;
        logic [15:0] exp_btn;
        logic [7:0]  exp_x;
        logic [7:0]  exp_y;
    } vec_t;

    vec_t vecs[7];

    logic [15:0] model_btn = '0;
    logic [7:0]  model_x   = '0;
    logic [7:0]  model_y   = '0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic checkRange(input string name, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic waitCop(input logic level, input int limit, input string name);
        int t;
        t = 0;
        while (cur_operation !== level && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (cur_operation !== level) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: wait expired, cur_operation=%b expected %b", name, cur_operation, level);
        end
    endtask

    // Controller data bit: 0 = 3U low / 1U high, 1 = 1U low / 3U high.
    task automatic sendBit(input logic b);
        dev_low = 1'b1;
        repeat (b ? U : 3 * U) @(negedge clk);
        dev_low = 1'b0;
        repeat (b ? 3 * U : U) @(negedge clk);
    endtask

    task automatic sendStop();
        dev_low = 1'b1;
        repeat (U) @(negedge clk);
        dev_low = 1'b0;
        repeat (2 * U) @(negedge clk);
    endtask

    // One full poll: wait for the host command, then answer with the
    // first nbits wire bits of reply (and a stop bit if complete).
    task automatic applyStimulus(input logic [31:0] reply, input int nbits, input bit stop);
        waitCop(1'b1, 4 * POLL_CYC, "poll_start");
        waitCop(1'b0, 400, "poll_tx_end");
        repeat (3) @(negedge clk);
        for (int i = 0; i < nbits; i++) sendBit(reply[i]);
        if (nbits == 32 && stop) sendStop();
        repeat (2 * TO_CYC + 10) @(negedge clk);
    endtask

    task automatic modelCommit(input logic [31:0] reply);
        model_btn = reply[15:0];
        model_x   = {<<{reply[23:16]}};
        model_y   = {<<{reply[31:24]}};
    endtask

    initial begin
        int          n;
        int          s0;
        int          d0;
        int          e0;
        int          hi_cnt;
        int          mism;
        int          nb;
        bit          st;
        logic [31:0] r;
        logic [7:0]  cmd;
        bit          samples[$];
        bit          expect_tx[$];

        vecs[0] = '{32'h81FE_0001, 32, 1'b1, 1, 16'h0001, 8'h7F, 8'h81};
        vecs[1] = '{32'h0000_0000,  0, 1'b1, 0, 16'h0001, 8'h7F, 8'h81};
        vecs[2] = '{32'hFFFF_FFFF, 20, 1'b1, 0, 16'h0001, 8'h7F, 8'h81};
        vecs[3] = '{32'h1234_5678, 32, 1'b0, 0, 16'h0001, 8'h7F, 8'h81};
        vecs[4] = '{32'h0180_8000, 32, 1'b1, 1, 16'h8000, 8'h01, 8'h80};
        vecs[5] = '{32'hFFFF_FFFF, 32, 1'b1, 1, 16'hFFFF, 8'hFF, 8'hFF};
        vecs[6] = '{32'h7F80_5A5A, 32, 1'b1, 1, 16'h5A5A, 8'h01, 8'hFE};

        // Reset state.
        rst_n   = 1'b0;
        enable  = 1'b0;
        dev_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {data_tx, cur_operation, poll_done, poll_error}, 4'b0000);
        checkOutput("reset_data", {button_state, stick_x, stick_y}, 32'h0);

        // Disabled: bus never driven.
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        hi_cnt = 0;
        repeat (3 * POLL_CYC) begin
            @(negedge clk);
            if (data_tx !== 1'b0) hi_cnt++;
        end
        checkOutput("disabled_tx_high", hi_cnt, 0);
        checkOutput("disabled_starts", start_cnt - s0, 0);

        // First poll timing after reset release with enable=1.
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 1000) begin
            @(posedge clk);
            n++;
            #1;
            if (data_tx === 1'b1) break;
        end
        checkOutput("first_rise", n, POLL_CYC);

        // Transmit waveform: 0x01 MSB first, then host stop bit.
        samples.delete();
        while (cur_operation === 1'b1 && samples.size() < 400) begin
            samples.push_back(data_tx);
            @(posedge clk);
            #1;
        end
        cmd = 8'h01;
        expect_tx.delete();
        for (int b = 7; b >= 0; b--) begin
            for (int c = 0; c < 4 * U; c++) expect_tx.push_back(c < (cmd[b] ? U : 3 * U));
        end
        for (int c = 0; c < 3 * U; c++) expect_tx.push_back(c < U);
        checkOutput("tx_length", samples.size(), 35 * U);
        mism = 0;
        for (int i = 0; i < expect_tx.size(); i++) begin
            if (i >= samples.size() || samples[i] != expect_tx[i]) mism++;
        end
        checkOutput("tx_waveform_mismatches", mism, 0);

        // No reply: timeout error, data kept, next poll after the gap.
        e0 = err_cnt;
        n = 0;
        while (poll_error !== 1'b1 && n < 400) begin
            @(posedge clk);
            n++;
            #1;
        end
        checkRange("timeout_delay", n, TO_CYC, TO_CYC + 3);
        @(negedge clk);
        checkOutput("timeout_err_pulses", err_cnt - e0, 1);
        checkOutput("timeout_keeps_data", {button_state, stick_x, stick_y}, 32'h0);
        n = 0;
        while (cur_operation !== 1'b1 && n < 4 * POLL_CYC) begin
            @(posedge clk);
            n++;
            #1;
        end
        checkRange("repoll_delay", n, POLL_CYC, POLL_CYC + 3);

        // Table-driven reply scenarios.
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            applyStimulus(vecs[i].reply, vecs[i].nbits, vecs[i].stop);
            checkOutput($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            checkOutput($sformatf("vec%0d_error", i), err_cnt - e0, 1 - vecs[i].exp_done);
            checkOutput($sformatf("vec%0d_button", i), button_state, vecs[i].exp_btn);
            checkOutput($sformatf("vec%0d_stick_x", i), stick_x, vecs[i].exp_x);
            checkOutput($sformatf("vec%0d_stick_y", i), stick_y, vecs[i].exp_y);
        end
        model_btn = vecs[6].exp_btn;
        model_x   = vecs[6].exp_x;
        model_y   = vecs[6].exp_y;

        // Random replies against the decode model.
        for (int k = 0; k < 8; k++) begin
            r  = $urandom;
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : 32;
            st = ($urandom_range(0, 4) != 0);
            d0 = done_cnt;
            e0 = err_cnt;
            applyStimulus(r, nb, st);
            if (nb == 32 && st) modelCommit(r);
            checkOutput($sformatf("rnd%0d_done", k), done_cnt - d0, (nb == 32 && st) ? 1 : 0);
            checkOutput($sformatf("rnd%0d_error", k), err_cnt - e0, (nb == 32 && st) ? 0 : 1);
            checkOutput($sformatf("rnd%0d_data", k), {button_state, stick_x, stick_y}, {model_btn, model_x, model_y});
        end

        // Reset during cell 3 of the command releases the bus next cycle.
        waitCop(1'b1, 4 * POLL_CYC, "rst_poll_start");
        repeat (8 * U + 5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_mid_tx_bus", {data_tx, cur_operation}, 2'b00);
        checkOutput("reset_mid_tx_data", {button_state, stick_x, stick_y}, 32'h0);
        model_btn = '0;
        model_x   = '0;
        model_y   = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // enable dropped mid-reply: this poll commits, no further polls.
        r = 32'hA5C3_3C5A;
        d0 = done_cnt;
        e0 = err_cnt;
        waitCop(1'b1, 4 * POLL_CYC, "en_poll_start");
        waitCop(1'b0, 400, "en_poll_tx_end");
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) sendBit(r[i]);
        enable = 1'b0;
        for (int i = 10; i < 32; i++) sendBit(r[i]);
        sendStop();
        repeat (2 * TO_CYC) @(negedge clk);
        modelCommit(r);
        checkOutput("en_drop_done", done_cnt - d0, 1);
        checkOutput("en_drop_error", err_cnt - e0, 0);
        checkOutput("en_drop_data", {button_state, stick_x, stick_y}, {model_btn, model_x, model_y});
        s0 = start_cnt;
        repeat (3 * POLL_CYC) @(negedge clk);
        checkOutput("en_drop_no_repoll", start_cnt - s0, 0);

        checkOutput("bus_driven_while_listening", viol_cnt, 0);
        checkOutput("done_and_error_together", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
